// File: rtl/gray_counter_updown.sv
// gray_counter_updown: parametrised up/down Gray counter with load, binary mirror and sticky wrap flags
// Ports: Clk, Reset (sync, active-high), En (count enable), Dir (0 up / 1 down),
//        Load + LoadValue (binary parallel load), ClrFlags (clear sticky flags),
//        Output (registered Gray count), Binary (registered binary count),
//        Overflow / Underflow (sticky up-wrap / down-wrap flags).
// Build option: define GRAY_SATURATE_EN to saturate at the ends instead of wrapping;
//        the flags still set on the blocked step.
module gray_counter_updown #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow
);
  localparam logic [WIDTH-1:0] one_v = WIDTH'(1);
  logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d, stepped;
  logic ovf_q, ovf_d, unf_q, unf_d, up_wrap, dn_wrap;
  always_comb begin
    up_wrap = En & ~Load & ~Dir & (&bin_q);
    dn_wrap = En & ~Load & Dir & ~(|bin_q);
`ifdef GRAY_SATURATE_EN
    stepped = (up_wrap | dn_wrap) ? bin_q : Dir ? bin_q - one_v : bin_q + one_v;
`else
    stepped = Dir ? bin_q - one_v : bin_q + one_v;
`endif
    bin_d = Reset ? '0 : Load ? LoadValue : En ? stepped : bin_q;
    gray_d = bin_d ^ (bin_d >> 1);
    ovf_d = Reset ? 1'b0 : up_wrap ? 1'b1 : ClrFlags ? 1'b0 : ovf_q;
    unf_d = Reset ? 1'b0 : dn_wrap ? 1'b1 : ClrFlags ? 1'b0 : unf_q;
  end
  always_ff @(posedge Clk) begin
    bin_q <= bin_d;
    gray_q <= gray_d;
    ovf_q <= ovf_d;
    unf_q <= unf_d;
  end
  assign Output = gray_q;
  assign Binary = bin_q;
  assign Overflow = ovf_q;
  assign Underflow = unf_q;
endmodule

// File: tb/tb_gray_counter_updown.sv
// tb_gray_counter_updown: directed vector bench for the 3-bit default build of gray_counter_updown
module tb_gray_counter_updown;
  logic clk = 1'b0;
  logic rst, en, dir, ld, clr;
  logic [2:0] lv, g, b;
  logic o, u;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic rst, en, dir, ld;
    logic [2:0] lv;
    logic clr;
    logic [2:0] eg, eb;
    logic eo, eu;
    string nm;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  gray_counter_updown #(.WIDTH(3)) dut (
    .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(ld), .LoadValue(lv),
    .ClrFlags(clr), .Output(g), .Binary(b), .Overflow(o), .Underflow(u)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic l, input logic [2:0] v, input logic c);
    rst = r; en = e; dir = d; ld = l; lv = v; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic e, input logic d, input logic l, input logic [2:0] v,
                     input logic c, input logic [2:0] eg, input logic [2:0] eb, input logic eo,
                     input logic eu, input string nm);
    vec_t x;
    x.rst = r; x.en = e; x.dir = d; x.ld = l; x.lv = v; x.clr = c;
    x.eg = eg; x.eb = eb; x.eo = eo; x.eu = eu; x.nm = nm;
    vecs.push_back(x);
  endtask

  initial begin
    logic [2:0] mb, prev;
    //   rst en dir ld lv clr  gray    bin   ovf  unf
    add(1, 0, 0, 0, 3'd0, 0, 3'b000, 3'd0, 0, 0, "reset");
    add(0, 1, 0, 0, 3'd0, 0, 3'b001, 3'd1, 0, 0, "up1");
    add(0, 1, 0, 0, 3'd0, 0, 3'b011, 3'd2, 0, 0, "up2");
    add(0, 1, 0, 0, 3'd0, 0, 3'b010, 3'd3, 0, 0, "up3");
    add(0, 1, 0, 0, 3'd0, 0, 3'b110, 3'd4, 0, 0, "up4");
    add(0, 1, 0, 0, 3'd0, 0, 3'b111, 3'd5, 0, 0, "up5");
    add(0, 1, 0, 0, 3'd0, 0, 3'b101, 3'd6, 0, 0, "up6");
    add(0, 1, 0, 0, 3'd0, 0, 3'b100, 3'd7, 0, 0, "up7");
    add(0, 1, 0, 0, 3'd0, 0, 3'b000, 3'd0, 1, 0, "up_wrap");
    add(1, 1, 1, 1, 3'd5, 0, 3'b000, 3'd0, 0, 0, "reset2");
    add(0, 1, 1, 0, 3'd0, 0, 3'b100, 3'd7, 0, 1, "dn_wrap");
    add(0, 1, 1, 0, 3'd0, 0, 3'b101, 3'd6, 0, 1, "dn6");
    add(0, 1, 0, 1, 3'd5, 0, 3'b111, 3'd5, 0, 1, "load5");
    add(0, 1, 0, 0, 3'd0, 0, 3'b101, 3'd6, 0, 1, "after_load");
    add(0, 1, 0, 0, 3'd0, 0, 3'b100, 3'd7, 0, 1, "up7b");
    add(0, 1, 0, 0, 3'd0, 0, 3'b000, 3'd0, 1, 1, "up_wrap2");
    add(0, 0, 0, 1, 3'd7, 0, 3'b100, 3'd7, 1, 1, "load7_flags_kept");
    add(0, 1, 0, 0, 3'd0, 1, 3'b000, 3'd0, 1, 0, "wrap_vs_clr");
    add(0, 0, 0, 0, 3'd0, 1, 3'b000, 3'd0, 0, 0, "clr");
    add(0, 1, 1, 0, 3'd0, 1, 3'b100, 3'd7, 0, 1, "dnwrap_vs_clr");
    add(0, 1, 0, 0, 3'd0, 0, 3'b000, 3'd0, 1, 1, "dir_flip");
    add(0, 1, 0, 0, 3'd0, 0, 3'b001, 3'd1, 1, 1, "c1");
    add(0, 1, 0, 0, 3'd0, 0, 3'b011, 3'd2, 1, 1, "c2");
    add(0, 1, 0, 0, 3'd0, 0, 3'b010, 3'd3, 1, 1, "c3");
    add(0, 1, 0, 0, 3'd0, 0, 3'b110, 3'd4, 1, 1, "c4");
    add(1, 1, 0, 1, 3'd6, 1, 3'b000, 3'd0, 0, 0, "reset_mid");
    add(0, 0, 0, 0, 3'd0, 0, 3'b000, 3'd0, 0, 0, "hold1");
    add(0, 0, 1, 0, 3'd0, 0, 3'b000, 3'd0, 0, 0, "hold2");
    add(0, 0, 0, 0, 3'd0, 0, 3'b000, 3'd0, 0, 0, "hold3");
    add(0, 0, 1, 1, 3'd3, 0, 3'b010, 3'd3, 0, 0, "load3");
    add(0, 0, 1, 0, 3'd0, 0, 3'b010, 3'd3, 0, 0, "hold_at3");
    rst = 1'b1; en = 1'b0; dir = 1'b0; ld = 1'b0; lv = 3'd0; clr = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].ld, vecs[i].lv, vecs[i].clr);
      chk({vecs[i].nm, ".gray"}, 32'(g), 32'(vecs[i].eg));
      chk({vecs[i].nm, ".bin"}, 32'(b), 32'(vecs[i].eb));
      chk({vecs[i].nm, ".ovf"}, 32'(o), 32'(vecs[i].eo));
      chk({vecs[i].nm, ".unf"}, 32'(u), 32'(vecs[i].eu));
    end
    drive(1, 0, 0, 0, 3'd0, 0);
    mb = 3'd0;
    prev = 3'd0;
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 1, 0, 3'd0, 0);
      mb = mb - 3'd1;
      chk("down_run.bin", 32'(b), 32'(mb));
      chk("down_run.gray", 32'(g), 32'(mb ^ (mb >> 1)));
      chk("down_run.one_bit", 32'($countones(g ^ prev)), 32'd1);
      chk("down_run.unf", 32'(u), 32'd1);
      chk("down_run.ovf", 32'(o), 32'd0);
      prev = g;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
